// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave datapath.
package i2c_pkg;

    localparam int I2C_BYTE_BITS           = 8;
    localparam int I2C_HOLD_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        HOLD,
        BIT,
        ACK_RISE,
        ACK_FALL
    } tx_state_e;

endpackage

// File: rtl/i2c_scl_edge_det.sv
// SCL edge detector: one-cycle rise/fall pulses from the filtered SCL.
module i2c_scl_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    output logic rise_o,
    output logic fall_o
);

    logic r_scl_q;

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl_q <= 1'b1;
        end else begin
            r_scl_q <= scl_i;
        end
    end

    assign fall_o = r_scl_q & ~scl_i;
    assign rise_o = ~r_scl_q & scl_i;

endmodule

// File: rtl/i2c_slave_tx_shifter.sv
// I2C slave transmit shifter: drives SDA open-drain enable MSB first with a
// fixed hold after each SCL fall, then samples the master ACK/NACK.
module i2c_slave_tx_shifter
    import i2c_pkg::*;
#(
    parameter int HOLD_CYCLES = I2C_HOLD_CYCLES_DEFAULT,
    parameter int CNT_W       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_filt_i,
    input  logic       sda_filt_i,
    input  logic       start_det_i,
    input  logic       stop_det_i,
    input  logic       tx_en_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       sda_oe_o,
    output logic       ack_valid_o,
    output logic       nack_o,
    output logic       busy_o,
    output logic       err_underrun_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       BITS_DONE = 4'(I2C_BYTE_BITS);

    tx_state_e        r_state;
    logic [7:0]       r_shreg;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_bit_cnt;
    logic             r_sda_oe;
    logic             r_ack_valid;
    logic             r_nack;
    logic             r_underrun;

    logic w_rise;
    logic w_fall;
    logic w_abort;
    logic w_ready;

    i2c_scl_edge_det u_scl_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .scl_i  (scl_filt_i),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign w_abort = (r_state != IDLE) && (start_det_i || stop_det_i || !tx_en_i);
    assign w_ready = ~rst_i & tx_en_i &
                     ((r_state == IDLE) | ((r_state == ACK_FALL) & ~r_nack));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_hold_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_sda_oe    <= 1'b0;
            r_ack_valid <= 1'b0;
            r_nack      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_ack_valid <= 1'b0;
            r_underrun  <= 1'b0;
            if (w_abort) begin
                r_state    <= IDLE;
                r_sda_oe   <= 1'b0;
                r_hold_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ready && tx_valid_i) begin
                            r_shreg   <= tx_data_i;
                            r_bit_cnt <= '0;
                            r_state   <= WAIT_FALL;
                        end
                    end
                    WAIT_FALL: begin
                        if (w_fall) begin
                            r_hold_cnt <= '0;
                            r_state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        if (r_hold_cnt == HOLD_LAST) begin
                            if (r_bit_cnt == BITS_DONE) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ACK_RISE;
                            end else begin
                                r_sda_oe <= ~r_shreg[7];
                                r_state  <= BIT;
                            end
                        end
                    end
                    BIT: begin
                        if (w_fall) begin
                            r_shreg    <= {r_shreg[6:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            r_hold_cnt <= '0;
                            r_state    <= HOLD;
                        end
                    end
                    ACK_RISE: begin
                        if (w_rise) begin
                            r_nack      <= sda_filt_i;
                            r_ack_valid <= 1'b1;
                            r_state     <= ACK_FALL;
                        end
                    end
                    ACK_FALL: begin
                        // The next byte goes straight into HOLD so its MSB uses this same fall.
                        if (r_nack) begin
                            r_state <= IDLE;
                        end else if (w_fall) begin
                            if (w_ready && tx_valid_i) begin
                                r_shreg    <= tx_data_i;
                                r_bit_cnt  <= '0;
                                r_hold_cnt <= '0;
                                r_state    <= HOLD;
                            end else begin
                                r_underrun <= 1'b1;
                                r_state    <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready_o     = w_ready;
    assign sda_oe_o       = r_sda_oe;
    assign ack_valid_o    = r_ack_valid;
    assign nack_o         = r_nack;
    assign busy_o         = (r_state != IDLE);
    assign err_underrun_o = r_underrun;

endmodule

// File: doc/i2c_slave_tx_shifter.md
Name: i2c_slave_tx_shifter

Overview:
Transmit datapath for the I2C slave. It shifts a byte out on SDA during master-read transfers. It takes filtered SCL/SDA from the input filter and START/STOP flags from the protocol FSM, and it drives an open-drain enable for the SDA pad. Each bit changes a fixed hold time after SCL falls. The block releases SDA for the ACK bit, samples the master ACK/NACK, and reports it to the protocol FSM, which supplies bytes over a valid/ready handshake.

Parameters:
HOLD_CYCLES, 4, clk cycles from the detected filtered SCL fall to the SDA update (tHD;DAT); legal range 1..15
CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W > HOLD_CYCLES

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
scl_filt_i  in  1  filtered SCL
sda_filt_i  in  1  filtered SDA, used for ACK sampling
start_det_i  in  1  one-cycle pulse on START or repeated START
stop_det_i  in  1  one-cycle pulse on STOP
tx_en_i  in  1  protocol FSM grants the transmit phase (slave-read)
tx_data_i  in  8  byte to send, MSB first
tx_valid_i  in  1  tx_data_i is valid
tx_ready_o  out  1  byte accepted when valid & ready
sda_oe_o  out  1  1 = pull SDA low; 0 = release
ack_valid_o  out  1  one-cycle pulse when the ACK bit is sampled
nack_o  out  1  sampled ACK bit value (1 = NACK); held until the next sample
busy_o  out  1  high in any state other than IDLE
err_underrun_o  out  1  one-cycle pulse: master ACKed but no next byte was valid

Behaviour:
- Clock and reset: single clock, clk_i. Reset is asynchronous and active-high on rst_i. On reset: state=IDLE, sda_oe_o=0, ack_valid_o=0, nack_o=0, busy_o=0, err_underrun_o=0, hold counter=0, bit counter=0, scl_q=1.
- tx_ready_o is combinational from state and tx_en_i. It is gated with ~rst_i, so it reads 0 during reset.
- Edge detect: scl_q <= scl_filt_i. fall = scl_q & ~scl_filt_i. rise = ~scl_q & scl_filt_i.
- Abort has the highest priority. start_det_i, stop_det_i, or ~tx_en_i in any non-IDLE state forces the next state to IDLE, clears sda_oe_o on the next edge, and clears both counters. Any fall/rise in the same cycle is ignored.
- IDLE:
  - tx_ready_o = tx_en_i.
  - On accept: shreg <= tx_data_i, bit_cnt <= 0, go to WAIT_FALL.
- WAIT_FALL: on fall, go to HOLD with hold_cnt <= 0.
- HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD_CYCLES-1:
    - if bit_cnt < 8: sda_oe_o <= ~shreg[7], go to BIT.
    - if bit_cnt == 8: sda_oe_o <= 0, go to ACK_RISE.
  - Net latency: sda_oe_o updates at the HOLD_CYCLES-th clk edge after the edge on which the fall was detected.
  - SCL edges seen during HOLD are ignored. The integrator guarantees tLOW > HOLD_CYCLES.
- BIT: on fall, shreg <= shreg<<1, bit_cnt++, go to HOLD with hold_cnt <= 0. The 8th fall (bit_cnt becomes 8) leads to release of SDA.
- ACK_RISE: on rise, nack_o <= sda_filt_i, ack_valid_o <= 1 for one cycle, go to ACK_FALL.
- ACK_FALL:
  - If nack_o: go to IDLE immediately. tx_ready_o = 0. SDA stays released.
  - Otherwise tx_ready_o = tx_en_i, and on fall:
    - if tx_valid_i: accept the byte, bit_cnt <= 0, go to HOLD. No WAIT_FALL, so there is no lost bit.
    - else: err_underrun_o pulse, go to IDLE, SDA stays released.
  - A handshake before the fall is not taken. Acceptance happens only on the fall cycle.
- Bit ordering: MSB first. sda_oe_o = inverted data bit, because open-drain drives low for 0.
- No clock stretching in this block. SCL is input-only.

Decomposition:
- i2c_pkg holds:
  - the state enum (IDLE, WAIT_FALL, HOLD, BIT, ACK_RISE, ACK_FALL)
  - the constant I2C_BYTE_BITS=8
  - the default HOLD_CYCLES
- One sub-module, i2c_scl_edge_det: scl_q register producing rise/fall pulses. The receive path shares it.

Test Plan:
- HOLD=4, send 0xA5, master ACKs -> sda_oe_o sequence 0,1,0,1,1,0,1,0, each change exactly 4 clk after its SCL fall. SDA released on the 9th bit. ack_valid_o pulse with nack_o=0.
- Send 0x00 then 0xFF; second byte held valid before the ACK-ending fall -> oe 1x8, release, then oe 0x8 with no gap. tx_ready_o handshakes exactly twice.
- Send 0x3C, master NACKs (SDA high at the 9th rise) -> nack_o=1, busy_o=0 next cycle, tx_ready_o never high in ACK_FALL, sda_oe_o=0.
- stop_det_i pulse after the 3rd bit of 0x0F, with sda_oe_o=1 -> sda_oe_o=0 and busy_o=0 on the next edge. A new byte is then accepted from IDLE.
- Master ACKs with tx_valid_i=0 at the ACK-ending fall -> err_underrun_o single-cycle pulse, state IDLE, sda_oe_o stays 0.
- Assert rst_i mid-byte while sda_oe_o=1 -> all outputs 0 without waiting for a clk edge. After release the block is in IDLE with scl_q=1.
